// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MC_WAIT  = 2'd2,
      MEM_WAIT = 2'd3
   } ctrl_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic src_match(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
      return uses && (rs == rd);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: load-use, branch flush, multicycle-EX and memory-wait handling.
//  state    | meaning
//  RUN      | normal issue; hazards resolved by priority each cycle
//  FLUSH    | extra post-branch cycles keeping IF/ID and ID/EX flushed
//  MC_WAIT  | front end frozen until the multicycle EX result is ready
//  MEM_WAIT | whole pipe frozen until data memory completes
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int FLUSH_EXTRA = 0,
   parameter int MC_TIMEOUT  = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             ex_mc_start,
   input  logic             ex_mc_done,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             idex_we,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_bubble,
   output logic             mc_timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int          MC_W       = $clog2(MC_TIMEOUT + 1);
   localparam logic [MC_W-1:0] MC_MAX = MC_W'(MC_TIMEOUT);
   localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_EXTRA);

   ctrl_state_t     state_q, state_d, ret_q, ret_d;
   logic [3:0]      flush_ctr_q, flush_ctr_d;
   logic [MC_W-1:0] mc_ctr_q, mc_ctr_d;
   logic            err_q, err_d;
   logic            mem_stall, load_use, flush_inc, stall_inc;

   assign mem_stall = mem_req && !mem_ready;
   assign load_use  = ex_memread && (ex_rd != REG_ZERO) &&
                      (src_match(id_uses_rs1, id_rs1, ex_rd) || src_match(id_uses_rs2, id_rs2, ex_rd));

   always_comb begin
      state_d      = state_q;
      ret_d        = ret_q;
      flush_ctr_d  = flush_ctr_q;
      mc_ctr_d     = mc_ctr_q;
      err_d        = err_q;
      flush_inc    = 1'b0;
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_we     = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      unique case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d = MEM_WAIT;
               ret_d   = RUN;
            end else if (ex_branch_taken) begin
               {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               flush_inc   = 1'b1;
               if (FLUSH_EXTRA > 0) begin
                  state_d     = FLUSH;
                  flush_ctr_d = FLUSH_INIT;
               end
            end else if (ex_mc_start) begin
               exmem_we     = 1'b1;
               memwb_we     = 1'b1;
               exmem_bubble = 1'b1;
               state_d      = MC_WAIT;
               mc_ctr_d     = '0;
            end else if (load_use) begin
               {idex_we, exmem_we, memwb_we} = 3'b111;
               idex_bubble = 1'b1;
            end else begin
               {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
            end
         end
         FLUSH: begin
            // a memory wait freezes the flush window; flush_ctr_q is kept
            if (mem_stall) begin
               state_d = MEM_WAIT;
               ret_d   = FLUSH;
            end else begin
               {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               flush_ctr_d = flush_ctr_q - 1'b1;
               if (flush_ctr_q <= 4'd1) begin
                  state_d     = RUN;
                  flush_ctr_d = '0;
               end
            end
         end
         MC_WAIT: begin
            if (ex_mc_done) begin
               {pc_we, ifid_we, exmem_we, memwb_we} = 4'b1111;
               state_d = RUN;
            end else begin
               exmem_we     = 1'b1;
               memwb_we     = 1'b1;
               exmem_bubble = 1'b1;
               if (mc_ctr_q != MC_MAX) mc_ctr_d = mc_ctr_q + 1'b1;
               if (mc_ctr_d == MC_MAX) err_d = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
               state_d = ret_q;
            end
         end
         default: state_d = RUN;
      endcase
      if (!rst) begin
         {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_bubble = 1'b1;
         flush_inc    = 1'b0;
      end
   end

   assign stall_inc      = rst && !pc_we;
   assign mc_timeout_err = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         ret_q       <= RUN;
         flush_ctr_q <= '0;
         mc_ctr_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         flush_ctr_q <= flush_ctr_d;
         mc_ctr_q    <= mc_ctr_d;
         err_q       <= err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush_inc),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: each driven cycle queues its expected controls, popped and compared mid-cycle.
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_memread = 0, ex_branch_taken = 0;
   logic ex_mc_start = 0, ex_mc_done = 0, mem_req = 0, mem_ready = 0;

   logic a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifl, a_idb, a_exb, a_err;
   logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifl, b_idb, b_exb, b_err;
   logic [3:0] a_stall, a_flush, b_stall, b_flush;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.FLUSH_EXTRA(2), .MC_TIMEOUT(64), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread),
      .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
      .ex_mc_done(ex_mc_done), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(a_pc), .ifid_we(a_ifid), .idex_we(a_idex), .exmem_we(a_exmem), .memwb_we(a_memwb),
      .ifid_flush(a_ifl), .idex_bubble(a_idb), .exmem_bubble(a_exb),
      .mc_timeout_err(a_err), .stall_cnt(a_stall), .flush_cnt(a_flush)
   );

   pipeline_hazard_ctrl #(.FLUSH_EXTRA(2), .MC_TIMEOUT(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread),
      .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
      .ex_mc_done(ex_mc_done), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(b_pc), .ifid_we(b_ifid), .idex_we(b_idex), .exmem_we(b_exmem), .memwb_we(b_memwb),
      .ifid_flush(b_ifl), .idex_bubble(b_idb), .exmem_bubble(b_exb),
      .mc_timeout_err(b_err), .stall_cnt(b_stall), .flush_cnt(b_flush)
   );

   // control vector order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble, exmem_bubble
   localparam logic [7:0] RSTV  = 8'b00000_111;
   localparam logic [7:0] RUNV  = 8'b11111_000;
   localparam logic [7:0] MEMV  = 8'b00000_000;
   localparam logic [7:0] FLV   = 8'b11111_110;
   localparam logic [7:0] MCV   = 8'b00011_001;
   localparam logic [7:0] DONEV = 8'b11011_000;
   localparam logic [7:0] LUV   = 8'b00111_010;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, memread, br, mcs, mcd, mreq, mrdy;
   } stim_t;
   localparam stim_t IDLE = '{rst: 1'b1, default: '0};

   typedef struct {
      string      tag;
      logic [7:0] ctl;
      logic [3:0] stall;
      logic [3:0] flush;
      logic       err_b;
   } exp_t;

   exp_t  sb[$];
   exp_t  e;
   stim_t nxt;
   int    errors = 0;
   int    checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [7:0] ctl, input int st, input int fl,
                      input logic eb);
      @(posedge clk);
      #1;
      rst = nxt.rst;
      id_rs1 = nxt.rs1; id_rs2 = nxt.rs2; ex_rd = nxt.rd;
      id_uses_rs1 = nxt.u1; id_uses_rs2 = nxt.u2; ex_memread = nxt.memread;
      ex_branch_taken = nxt.br; ex_mc_start = nxt.mcs; ex_mc_done = nxt.mcd;
      mem_req = nxt.mreq; mem_ready = nxt.mrdy;
      sb.push_back('{tag: tag, ctl: ctl, stall: 4'(st), flush: 4'(fl), err_b: eb});
      nxt = IDLE;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq({e.tag, "/ctl"}, 32'({a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifl, a_idb, a_exb}),
                  32'(e.ctl));
         check_eq({e.tag, "/stall"}, 32'(a_stall), 32'(e.stall));
         check_eq({e.tag, "/flush"}, 32'(a_flush), 32'(e.flush));
         check_eq({e.tag, "/err_a"}, 32'(a_err), 32'(0));
         check_eq({e.tag, "/err_b"}, 32'(b_err), 32'(e.err_b));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nxt = IDLE;
      // T1 reset held, then released
      for (int i = 0; i < 3; i++) begin
         nxt.rst = 1'b0;
         cyc("rst_hold", RSTV, 0, 0, 0);
      end
      cyc("rst_rel", RUNV, 0, 0, 0);
      cyc("idle", RUNV, 0, 0, 0);

      // T2 load-use on rs2, rd=0 immunity, rs1 match, unused source
      nxt.memread = 1; nxt.rd = 5; nxt.rs2 = 5; nxt.u2 = 1;
      cyc("lu_rs2", LUV, 0, 0, 0);
      cyc("lu_after", RUNV, 1, 0, 0);
      nxt.memread = 1; nxt.rd = 0; nxt.rs2 = 0; nxt.u2 = 1;
      cyc("lu_rd0", RUNV, 1, 0, 0);
      nxt.memread = 1; nxt.rd = 7; nxt.rs1 = 7; nxt.u1 = 1;
      cyc("lu_rs1", LUV, 1, 0, 0);
      cyc("lu_rs1_after", RUNV, 2, 0, 0);
      nxt.memread = 1; nxt.rd = 7; nxt.rs1 = 7; nxt.u1 = 0;
      cyc("lu_unused", RUNV, 2, 0, 0);

      // T3 branch with two extra flush cycles, then branch plus load-use
      nxt.br = 1;
      cyc("br", FLV, 2, 0, 0);
      cyc("br_fl1", FLV, 2, 1, 0);
      cyc("br_fl2", FLV, 2, 1, 0);
      cyc("br_done", RUNV, 2, 1, 0);
      nxt.br = 1; nxt.memread = 1; nxt.rd = 5; nxt.rs2 = 5; nxt.u2 = 1;
      cyc("br_lu", FLV, 2, 1, 0);
      cyc("br_lu_fl1", FLV, 2, 2, 0);
      cyc("br_lu_fl2", FLV, 2, 2, 0);
      cyc("br_lu_done", RUNV, 2, 2, 0);

      // T5 memory wait inside FLUSH keeps the remaining flush window
      nxt.br = 1;
      cyc("mw_br", FLV, 2, 2, 0);
      nxt.mreq = 1;
      cyc("mw_w1", MEMV, 2, 3, 0);
      nxt.mreq = 1;
      cyc("mw_w2", MEMV, 3, 3, 0);
      nxt.mreq = 1;
      cyc("mw_w3", MEMV, 4, 3, 0);
      nxt.mreq = 1; nxt.mrdy = 1;
      cyc("mw_rdy", RUNV, 5, 3, 0);
      cyc("mw_fl1", FLV, 5, 3, 0);
      cyc("mw_fl2", FLV, 5, 3, 0);
      cyc("mw_run", RUNV, 5, 3, 0);
      nxt.mreq = 1; nxt.br = 1;
      cyc("mw_over_br", MEMV, 5, 3, 0);
      nxt.mrdy = 1;
      cyc("mw_rdy2", RUNV, 6, 3, 0);
      cyc("mw_idle", RUNV, 6, 3, 0);

      // T4 multicycle: five wait cycles then done; dut_b times out after four
      nxt.mcs = 1;
      cyc("mc_start", MCV, 6, 3, 0);
      cyc("mc_w1", MCV, 7, 3, 0);
      cyc("mc_w2", MCV, 8, 3, 0);
      nxt.br = 1;
      cyc("mc_w3_br", MCV, 9, 3, 0);
      cyc("mc_w4", MCV, 10, 3, 0);
      cyc("mc_w5", MCV, 11, 3, 1);
      nxt.mcd = 1;
      cyc("mc_done", DONEV, 12, 3, 1);
      cyc("mc_after", RUNV, 12, 3, 1);

      // T6 stall counter saturation
      for (int i = 0; i < 4; i++) begin
         nxt.memread = 1; nxt.rd = 9; nxt.rs1 = 9; nxt.u1 = 1;
         cyc("sat_lu", LUV, 12 + i, 3, 1);
         cyc("sat_run", RUNV, (i < 2) ? 13 + i : 15, 3, 1);
      end

      // T6 async reset mid-MC_WAIT clears everything
      nxt.mcs = 1;
      cyc("rmc_start", MCV, 15, 3, 1);
      cyc("rmc_w1", MCV, 15, 3, 1);
      nxt.rst = 1'b0;
      cyc("rmc_rst", RSTV, 0, 0, 0);
      cyc("rmc_rel", RUNV, 0, 0, 0);
      cyc("rmc_idle", RUNV, 0, 0, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      check_eq("sb_drained", 32'(sb.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
